// File: rtl/chaos_pkg.sv
// Shared types, Q8.24 constants and arithmetic helpers for the 4D hyperchaotic Lorenz key generator.
package chaos_pkg;

    localparam int FRAC_BITS = 24;
    localparam int WIDE_BITS = 36;

    typedef logic signed [31:0]          state_t;
    typedef logic signed [WIDE_BITS-1:0] wide_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_XZ,
        ST_MUL_XY,
        ST_MUL_YZ,
        ST_UPD,
        ST_FIN
    } fsm_t;

    localparam wide_t SAT_MAX = 36'sh0_7FFF_FFFF;
    localparam wide_t SAT_MIN = 36'shF_8000_0000;

    function automatic wide_t widen(input state_t s);
        return wide_t'(s);
    endfunction

    function automatic state_t sat32(input wide_t v);
        if (v > SAT_MAX) return 32'sh7FFF_FFFF;
        if (v < SAT_MIN) return 32'sh8000_0000;
        return v[31:0];
    endfunction

    function automatic wide_t times10(input wide_t d);
        return (d <<< 3) + (d <<< 1);
    endfunction

    function automatic wide_t times28(input state_t x);
        wide_t xw;
        xw = widen(x);
        return (xw <<< 5) - (xw <<< 2);
    endfunction

    // b = 2.65625 as 2 + 1/2 + 1/8 + 1/32; each term truncates on its own
    function automatic wide_t times_b(input state_t z);
        wide_t zw;
        zw = widen(z);
        return (zw <<< 1) + (zw >>> 1) + (zw >>> 3) + (zw >>> 5);
    endfunction

    function automatic logic [7:0] byte_at(input state_t s, input logic [4:0] ofs);
        logic [31:0] t;
        t = 32'(s) >> ofs;
        return t[7:0];
    endfunction

endpackage

// File: rtl/chaos_key_gen_mul.sv
// Registered signed 32x32 multiplier returning the Q8.24 slice of the product (wraps, no saturation).
module chaos_mul_q824
    import chaos_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  state_t a,
    input  state_t b,
    output state_t p
);

    logic signed [63:0] prod;
    state_t             p_d;
    state_t             p_q;

    always_comb begin
        prod = 64'(a) * 64'(b);
        p_d  = prod[FRAC_BITS+31:FRAC_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
    end

    assign p = p_q;

endmodule

// File: rtl/chaos_key_gen.sv
// Hyperchaotic Lorenz engine: each step request runs N Euler iterations through one shared multiplier,
// four cycles per iteration, then latches a byte window of every state variable.
module chaos_key_gen
    import chaos_pkg::*;
#(
    parameter int          DT_SHIFT = 8,
    parameter logic [31:0] X0       = 32'h0100_0000,
    parameter logic [31:0] Y0       = 32'h0100_0000,
    parameter logic [31:0] Z0       = 32'h0100_0000,
    parameter logic [31:0] W0       = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chaos_reset,
    input  logic        chaos_step,
    input  logic [31:0] chaos_shift,
    output logic        chaos_done,
    output logic [7:0]  chaos_x,
    output logic [7:0]  chaos_y,
    output logic [7:0]  chaos_z,
    output logic [7:0]  chaos_w
);

    fsm_t        fsm_q, fsm_d;
    logic        step_q;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  ofs_q, ofs_d;
    state_t      x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
    state_t      p_xz_q, p_xz_d, p_xy_q, p_xy_d;
    logic        done_q, done_d;
    logic [7:0]  ox_q, ox_d, oy_q, oy_d, oz_q, oz_d, ow_q, ow_d;

    state_t      mul_a, mul_b, mul_p;
    wide_t       dx, dy, dz, dw;
    logic        step_go;

    // A rise that coincides with chaos_reset is dropped, not deferred
    assign step_go = chaos_step & ~step_q & ~chaos_reset;

    function automatic state_t euler(input state_t s, input wide_t ds);
        return sat32(widen(s) + (ds >>> DT_SHIFT));
    endfunction

    chaos_mul_q824 u_mul (
        .clk   (clk),
        .rst_n (reset_n),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    // In UPD the multiplier output holds y*z; x*z and x*y were parked on the two previous cycles
    assign dx = times10(widen(y_q) - widen(x_q)) + widen(w_q);
    assign dy = times28(x_q) - widen(y_q) - widen(p_xz_q);
    assign dz = widen(p_xy_q) - times_b(z_q);
    assign dw = widen(w_q >>> 1) - widen(mul_p);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= ST_IDLE;
            step_q <= 1'b0;
            cnt_q  <= '0;
            ofs_q  <= '0;
            x_q    <= state_t'(X0);
            y_q    <= state_t'(Y0);
            z_q    <= state_t'(Z0);
            w_q    <= state_t'(W0);
            p_xz_q <= '0;
            p_xy_q <= '0;
            done_q <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
            oz_q   <= '0;
            ow_q   <= '0;
        end else begin
            fsm_q  <= fsm_d;
            step_q <= chaos_step;
            cnt_q  <= cnt_d;
            ofs_q  <= ofs_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            w_q    <= w_d;
            p_xz_q <= p_xz_d;
            p_xy_q <= p_xy_d;
            done_q <= done_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            oz_q   <= oz_d;
            ow_q   <= ow_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (chaos_reset) begin
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE:   if (step_go) fsm_d = ST_MUL_XZ;
                ST_MUL_XZ: fsm_d = ST_MUL_XY;
                ST_MUL_XY: fsm_d = ST_MUL_YZ;
                ST_MUL_YZ: fsm_d = ST_UPD;
                ST_UPD:    fsm_d = (cnt_q == 16'd1) ? ST_FIN : ST_MUL_XZ;
                ST_FIN:    fsm_d = ST_IDLE;
                default:   fsm_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        ofs_d  = ofs_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        w_d    = w_q;
        p_xz_d = p_xz_q;
        p_xy_d = p_xy_q;
        done_d = done_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        oz_d   = oz_q;
        ow_d   = ow_q;
        mul_a  = y_q;
        mul_b  = z_q;
        case (fsm_q)
            ST_IDLE: begin
                if (step_go) begin
                    cnt_d  = (chaos_shift[15:0] == 16'd0) ? 16'd1 : chaos_shift[15:0];
                    ofs_d  = (chaos_shift[20:16] > 5'd24) ? 5'd24 : chaos_shift[20:16];
                    done_d = 1'b0;
                end
            end
            ST_MUL_XZ: begin
                mul_a = x_q;
                mul_b = z_q;
            end
            ST_MUL_XY: begin
                mul_a  = x_q;
                mul_b  = y_q;
                p_xz_d = mul_p;
            end
            ST_MUL_YZ: p_xy_d = mul_p;
            ST_UPD: begin
                x_d   = euler(x_q, dx);
                y_d   = euler(y_q, dy);
                z_d   = euler(z_q, dz);
                w_d   = euler(w_q, dw);
                cnt_d = cnt_q - 16'd1;
            end
            ST_FIN: begin
                ox_d   = byte_at(x_q, ofs_q);
                oy_d   = byte_at(y_q, ofs_q);
                oz_d   = byte_at(z_q, ofs_q);
                ow_d   = byte_at(w_q, ofs_q);
                done_d = 1'b1;
            end
            default: ;
        endcase
        if (chaos_reset) begin
            x_d    = state_t'(X0);
            y_d    = state_t'(Y0);
            z_d    = state_t'(Z0);
            w_d    = state_t'(W0);
            done_d = 1'b0;
        end
    end

    assign chaos_done = done_q;
    assign chaos_x    = ox_q;
    assign chaos_y    = oy_q;
    assign chaos_z    = oz_q;
    assign chaos_w    = ow_q;

endmodule

// File: tb/tb_chaos_key_gen.sv
// Self-checking bench for chaos_key_gen against a plain-arithmetic Euler reference model.
module tb_chaos_key_gen;

    localparam int DT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chaos_reset, chaos_step;
    logic [31:0] chaos_shift;
    logic        chaos_done;
    logic [7:0]  chaos_x, chaos_y, chaos_z, chaos_w;

    logic        sat_step;
    logic        sat_done;
    logic [7:0]  sat_x, sat_y, sat_z, sat_w;

    int total = 0;
    int bad   = 0;

    int          mx, my, mz, mw;
    logic [31:0] mo;

    always #5 clk = ~clk;

    chaos_key_gen #(.DT_SHIFT(DT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chaos_reset (chaos_reset),
        .chaos_step  (chaos_step),
        .chaos_shift (chaos_shift),
        .chaos_done  (chaos_done),
        .chaos_x     (chaos_x),
        .chaos_y     (chaos_y),
        .chaos_z     (chaos_z),
        .chaos_w     (chaos_w)
    );

    chaos_key_gen #(
        .DT_SHIFT (DT),
        .X0       (32'h7F80_0000),
        .Y0       (32'h7FFF_FFFF),
        .Z0       (32'h0000_0000),
        .W0       (32'h7F00_0000)
    ) dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .chaos_reset (1'b0),
        .chaos_step  (sat_step),
        .chaos_shift (32'h0018_0001),
        .chaos_done  (sat_done),
        .chaos_x     (sat_x),
        .chaos_y     (sat_y),
        .chaos_z     (sat_z),
        .chaos_w     (sat_w)
    );

    // ---------------- reference model ----------------
    function automatic longint wrap36(input longint v);
        return (v <<< 28) >>> 28;
    endfunction

    function automatic int sat(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return int'(32'h8000_0000);
        return int'(v);
    endfunction

    function automatic int mulq(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 24);
    endfunction

    task automatic model_iter();
        longint x, y, z, w, xz, xy, yz, dx, dy, dz, dw;
        x = mx; y = my; z = mz; w = mw;
        xz = mulq(mx, mz);
        xy = mulq(mx, my);
        yz = mulq(my, mz);
        dx = wrap36(10 * (y - x) + w);
        dy = wrap36(28 * x - y - xz);
        dz = wrap36(xy - ((z <<< 1) + (z >>> 1) + (z >>> 3) + (z >>> 5)));
        dw = wrap36(-yz + (w >>> 1));
        mx = sat(x + (dx >>> DT));
        my = sat(y + (dy >>> DT));
        mz = sat(z + (dz >>> DT));
        mw = sat(w + (dw >>> DT));
    endtask

    function automatic logic [7:0] mbyte(input int s, input int ofs);
        logic [31:0] t;
        t = s;
        t = t >> ofs;
        return t[7:0];
    endfunction

    task automatic model_reload();
        mx = 32'h0100_0000; my = 32'h0100_0000; mz = 32'h0100_0000; mw = 32'h0100_0000;
    endtask

    // Drives one step edge, returns edges from the accepting edge to done, and advances the model
    task automatic run_step(input logic [31:0] sh, output int lat);
        int n, ofs;
        n   = (sh[15:0] == 16'd0) ? 1 : int'(sh[15:0]);
        ofs = (sh[20:16] > 5'd24) ? 24 : int'(sh[20:16]);
        @(negedge clk);
        chaos_shift = sh;
        chaos_step  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = (chaos_done === 1'b0) ? 0 : -1;
        if (lat == 0) begin
            while (lat < 4 * n + 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (chaos_done === 1'b1) break;
            end
        end
        chaos_step = 1'b0;
        for (int i = 0; i < n; i++) model_iter();
        mo = {mbyte(mx, ofs), mbyte(my, ofs), mbyte(mz, ofs), mbyte(mw, ofs)};
    endtask

    task automatic pulse_chaos_reset();
        @(negedge clk);
        chaos_reset = 1'b1;
        @(negedge clk);
        chaos_reset = 1'b0;
        model_reload();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; chaos_reset = 1'b0; chaos_step = 1'b0; chaos_shift = '0; sat_step = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({chaos_done, chaos_x, chaos_y, chaos_z, chaos_w} !== 33'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {chaos_done, chaos_x, chaos_y, chaos_z, chaos_w});
        end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {4{32'h0100_0000}}) begin
            bad++; $display("FAIL reset_states: got %h want 01000000 x4", {dut.x_q, dut.y_q, dut.z_q, dut.w_q});
        end
        reset_n = 1'b1;
        model_reload();
        mo = '0;
        $display("reset: done=%0d outs=%h", chaos_done, {chaos_x, chaos_y, chaos_z, chaos_w});
    endtask

    task automatic test_basic();
        int lat;
        run_step(32'h0010_0001, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== 128'h01010000_011A0000_00FE5800_00FF8000) begin
            bad++; $display("FAIL basic_states: got %h want 01010000011a000000fe580000ff8000",
                            {dut.x_q, dut.y_q, dut.z_q, dut.w_q});
        end
        total++;
        if ({mx, my, mz, mw} !== {dut.x_q, dut.y_q, dut.z_q, dut.w_q}) begin
            bad++; $display("FAIL basic_model: got %h want %h", {dut.x_q, dut.y_q, dut.z_q, dut.w_q}, {mx, my, mz, mw});
        end
        total++;
        if ({chaos_x, chaos_y, chaos_z, chaos_w} !== 32'h011A_FEFF) begin
            bad++; $display("FAIL basic_outputs: got %h want 011afeff", {chaos_x, chaos_y, chaos_z, chaos_w});
        end
        $display("basic: lat=%0d outs=%h", lat, {chaos_x, chaos_y, chaos_z, chaos_w});
    endtask

    task automatic test_ofs();
        int lat;
        logic [31:0] shifts [2];
        shifts[0] = 32'h0018_0001;
        shifts[1] = 32'h001F_0001;
        for (int i = 0; i < 2; i++) begin
            pulse_chaos_reset();
            run_step(shifts[i], lat);
            total++;
            if ({chaos_x, chaos_y, chaos_z, chaos_w} !== 32'h0101_0000 || lat !== 5) begin
                bad++; $display("FAIL ofs_%0d: got outs=%h lat=%0d want 01010000 lat=5",
                                i, {chaos_x, chaos_y, chaos_z, chaos_w}, lat);
            end
            $display("ofs: shift=%h outs=%h", shifts[i], {chaos_x, chaos_y, chaos_z, chaos_w});
        end
    endtask

    task automatic test_long();
        int lat;
        logic [31:0] shifts [2];
        int          want [2];
        shifts[0] = 32'h0000_0064; want[0] = 401;
        shifts[1] = 32'h0010_0000; want[1] = 5;
        for (int i = 0; i < 2; i++) begin
            run_step(shifts[i], lat);
            total++;
            if (lat !== want[i]) begin bad++; $display("FAIL long_latency_%0d: got %0d want %0d", i, lat, want[i]); end
            total++;
            if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {mx, my, mz, mw}) begin
                bad++; $display("FAIL long_states_%0d: got %h want %h", i, {dut.x_q, dut.y_q, dut.z_q, dut.w_q}, {mx, my, mz, mw});
            end
            total++;
            if ({chaos_x, chaos_y, chaos_z, chaos_w} !== mo) begin
                bad++; $display("FAIL long_outputs_%0d: got %h want %h", i, {chaos_x, chaos_y, chaos_z, chaos_w}, mo);
            end
            $display("long: shift=%h lat=%0d outs=%h", shifts[i], lat, {chaos_x, chaos_y, chaos_z, chaos_w});
        end
    endtask

    task automatic test_random();
        int lat, n;
        logic [31:0] sh;
        for (int i = 0; i < 8; i++) begin
            sh = {11'($urandom), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 12))};
            n  = (sh[15:0] == 16'd0) ? 1 : int'(sh[15:0]);
            run_step(sh, lat);
            total++;
            if (lat !== 4 * n + 1) begin bad++; $display("FAIL rand_latency_%0d: got %0d want %0d", i, lat, 4 * n + 1); end
            total++;
            if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {mx, my, mz, mw}) begin
                bad++; $display("FAIL rand_states_%0d: got %h want %h", i, {dut.x_q, dut.y_q, dut.z_q, dut.w_q}, {mx, my, mz, mw});
            end
            total++;
            if ({chaos_x, chaos_y, chaos_z, chaos_w} !== mo) begin
                bad++; $display("FAIL rand_outputs_%0d: got %h want %h", i, {chaos_x, chaos_y, chaos_z, chaos_w}, mo);
            end
            $display("random: shift=%h lat=%0d outs=%h", sh, lat, {chaos_x, chaos_y, chaos_z, chaos_w});
        end
    endtask

    task automatic test_hold();
        int rises, rise_edge;
        logic prev;
        rises = 0; rise_edge = -1;
        @(negedge clk);
        chaos_shift = 32'h0008_0003;
        chaos_step  = 1'b1;
        prev = chaos_done;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (chaos_done === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rise_edge < 0) rise_edge = e;
            end
            prev = chaos_done;
        end
        chaos_step = 1'b0;
        for (int i = 0; i < 3; i++) model_iter();
        mo = {mbyte(mx, 8), mbyte(my, 8), mbyte(mz, 8), mbyte(mw, 8)};
        total++;
        if (rises !== 1 || rise_edge !== 13) begin
            bad++; $display("FAIL hold_single_run: got rises=%0d at edge %0d want 1 at edge 13", rises, rise_edge);
        end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {mx, my, mz, mw}) begin
            bad++; $display("FAIL hold_states: got %h want %h", {dut.x_q, dut.y_q, dut.z_q, dut.w_q}, {mx, my, mz, mw});
        end
        $display("hold: rises=%0d edge=%0d", rises, rise_edge);
    endtask

    task automatic test_busy_edge();
        int k, drops;
        @(negedge clk);
        chaos_shift = 32'h0010_0005;
        chaos_step  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chaos_step = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chaos_step = 1'b1;
        k = 2;
        while (k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (chaos_done === 1'b1) break;
        end
        drops = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (chaos_done !== 1'b1) drops++;
        end
        chaos_step = 1'b0;
        for (int i = 0; i < 5; i++) model_iter();
        mo = {mbyte(mx, 16), mbyte(my, 16), mbyte(mz, 16), mbyte(mw, 16)};
        total++;
        if (k !== 21 || drops !== 0) begin
            bad++; $display("FAIL busy_edge: got lat=%0d drops=%0d want lat=21 drops=0", k, drops);
        end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w} !== {mx, my, mz, mw, mo}) begin
            bad++; $display("FAIL busy_states: got %h want %h",
                            {dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w}, {mx, my, mz, mw, mo});
        end
        $display("busy_edge: lat=%0d drops=%0d", k, drops);
    endtask

    task automatic test_chaos_reset();
        int seen, lat;
        logic [31:0] outs_before;
        outs_before = {chaos_x, chaos_y, chaos_z, chaos_w};
        @(negedge clk);
        chaos_shift = 32'h0010_000A;
        chaos_step  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chaos_reset = 1'b1;
        @(negedge clk);
        chaos_reset = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (chaos_done !== 1'b0) seen++;
        end
        chaos_step = 1'b0;
        model_reload();
        total++;
        if (seen !== 0) begin bad++; $display("FAIL creset_done: got %0d done cycles want 0", seen); end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w} !== {mx, my, mz, mw, outs_before}) begin
            bad++; $display("FAIL creset_states: got %h want %h",
                            {dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w}, {mx, my, mz, mw, outs_before});
        end
        // a rise that lands during chaos_reset must be lost even though the level stays high
        @(negedge clk);
        chaos_reset = 1'b1;
        chaos_step  = 1'b1;
        @(negedge clk);
        chaos_reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (chaos_done !== 1'b0) seen++;
        end
        chaos_step = 1'b0;
        total++;
        if (seen !== 0 || {dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {mx, my, mz, mw}) begin
            bad++; $display("FAIL creset_lost_edge: got done_cycles=%0d states=%h want 0 and %h",
                            seen, {dut.x_q, dut.y_q, dut.z_q, dut.w_q}, {mx, my, mz, mw});
        end
        run_step(32'h0010_0001, lat);
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w}
            !== 160'h01010000_011A0000_00FE5800_00FF8000_011AFEFF || lat !== 5) begin
            bad++; $display("FAIL creset_replay: got %h lat=%0d want first-run values lat=5",
                            {dut.x_q, dut.y_q, dut.z_q, dut.w_q, chaos_x, chaos_y, chaos_z, chaos_w}, lat);
        end
        $display("chaos_reset: replay outs=%h", {chaos_x, chaos_y, chaos_z, chaos_w});
    endtask

    task automatic test_saturation();
        int k, sx, sy, sz, sw;
        logic [31:0] so;
        sx = mx; sy = my; sz = mz; sw = mw;
        mx = 32'h7F80_0000; my = 32'h7FFF_FFFF; mz = 0; mw = 32'h7F00_0000;
        model_iter();
        so = {mbyte(mx, 24), mbyte(my, 24), mbyte(mz, 24), mbyte(mw, 24)};
        @(negedge clk);
        sat_step = 1'b1;
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (sat_done === 1'b1) break;
        end
        sat_step = 1'b0;
        total++;
        if (dut_sat.x_q !== 32'h7FFF_FFFF || k !== 6) begin
            bad++; $display("FAIL sat_x: got %h after %0d edges want 7fffffff after 6", dut_sat.x_q, k);
        end
        total++;
        if ({dut_sat.x_q, dut_sat.y_q, dut_sat.z_q, dut_sat.w_q, sat_x, sat_y, sat_z, sat_w} !== {mx, my, mz, mw, so}) begin
            bad++; $display("FAIL sat_model: got %h want %h",
                            {dut_sat.x_q, dut_sat.y_q, dut_sat.z_q, dut_sat.w_q, sat_x, sat_y, sat_z, sat_w}, {mx, my, mz, mw, so});
        end
        $display("saturation: x=%h y=%h", dut_sat.x_q, dut_sat.y_q);
        mx = sx; my = sy; mz = sz; mw = sw;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        chaos_shift = 32'h0000_000A;
        chaos_step  = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({chaos_done, chaos_x, chaos_y, chaos_z, chaos_w} !== 33'd0) begin
            bad++; $display("FAIL async_outputs: got %h want 0", {chaos_done, chaos_x, chaos_y, chaos_z, chaos_w});
        end
        total++;
        if ({dut.x_q, dut.y_q, dut.z_q, dut.w_q} !== {4{32'h0100_0000}}) begin
            bad++; $display("FAIL async_states: got %h want 01000000 x4", {dut.x_q, dut.y_q, dut.z_q, dut.w_q});
        end
        @(negedge clk);
        chaos_step = 1'b0;
        reset_n    = 1'b1;
        model_reload();
        mo = '0;
        $display("async_reset: outs=%h", {chaos_x, chaos_y, chaos_z, chaos_w});
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ofs();
        test_long();
        test_random();
        test_hold();
        test_busy_edge();
        test_chaos_reset();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chaos_key_gen.md
Name: chaos_key_gen

Overview:
- 4D hyperchaotic Lorenz generator in Q8.24 fixed point. Sits beside the Nios Qsys system as the fabric-side engine behind the chaos PIOs.
- Consumes `chaos_reset`, `chaos_step` and `chaos_shift` (PIO outputs). Produces the `chaos_x`/`y`/`z`/`w` bytes and `chaos_done` (PIO inputs).
- Each step request runs N Euler iterations, using one shared registered multiplier.

Parameters:
- DT_SHIFT, 8, Euler step dt = 2^-DT_SHIFT (arithmetic right shift)
- X0, 32'h01000000, initial x (Q8.24, 1.0)
- Y0, 32'h01000000, initial y
- Z0, 32'h01000000, initial z
- W0, 32'h01000000, initial w

Ports:
- clk  in  1  system clock (same clock as the Qsys system)
- reset_n  in  1  asynchronous active-low reset
- chaos_reset  in  1  synchronous reload of initial conditions, level sensitive
- chaos_step  in  1  rising edge starts a run
- chaos_shift  in  32  [15:0] iteration count N (0 treated as 1); [20:16] output bit offset OFS (values >24 clamp to 24); [31:21] ignored
- chaos_done  out  1  run complete, outputs valid
- chaos_x  out  8  state_x[OFS+7:OFS]
- chaos_y  out  8  state_y[OFS+7:OFS]
- chaos_z  out  8  state_z[OFS+7:OFS]
- chaos_w  out  8  state_w[OFS+7:OFS]

Behaviour:
- Reset (reset_n=0, async):
  - state_x/y/z/w = X0/Y0/Z0/W0; FSM=IDLE.
  - chaos_done=0; chaos_x/y/z/w = 0; step edge register = 0.
- Step request: `step_rise = chaos_step & ~step_q`, with step_q registered every cycle. A level held high triggers exactly once.
- chaos_shift is sampled into N_reg and OFS_reg on the accepted `step_rise` and held for the whole run.
- FSM states: IDLE, MUL_XZ, MUL_XY, MUL_YZ, UPD, FIN.
  - IDLE, step_rise -> MUL_XZ; chaos_done<=0; iteration counter <= N_reg (min 1).
  - MUL_XZ -> MUL_XY -> MUL_YZ: each state registers one signed 32x32 product, keeping bits [55:24] (Q8.24 result).
  - UPD: all four states update simultaneously from the old values. Decrement the counter; if it reaches 0 -> FIN, else -> MUL_XZ.
  - FIN: latch the output bytes using OFS_reg; chaos_done<=1 -> IDLE.
- Latency: step_rise at cycle 0 gives chaos_done=1 at cycle 4N+1.
- chaos_done and the output bytes hold until the next accepted step_rise (done clears the cycle after it) or until chaos_reset.
- Derivatives (all 32-bit signed Q8.24, intermediates 36-bit):
  - dx = 10*(y-x) + w, computed as (d<<3)+(d<<1)
  - dy = 28*x - y - xz, with 28x computed as (x<<5)-(x<<2)
  - dz = xy - b*z, with b*z = (z<<1)+(z>>1)+(z>>3)+(z>>5) (b=2.65625)
  - dw = -yz + (w>>>1)
- Update: `s_new = sat32(s + (ds >>> DT_SHIFT))`. sat32 clamps to 32'h7FFFFFFF / 32'h80000000. Right shifts are arithmetic.
- Multiplier product keeps bits [55:24] without saturation (wraps); only the state sums saturate.
- chaos_reset=1:
  - Any cycle, any state: reload X0..W0, FSM->IDLE, chaos_done=0. Output bytes are unchanged.
  - Wins over a simultaneous step_rise, which is dropped.
  - A step_rise while chaos_reset is high is lost; the step level must toggle again.
- step_rise while busy (not IDLE): ignored; the current run completes normally.
- State persists across runs: consecutive steps continue the trajectory.

Decomposition:
- Package chaos_pkg:
  - state_t (signed 32) and the Q8.24 FRAC_BITS=24 constant
  - FSM enum
  - sat32 function
  - coefficient shift-add functions
- One sub-module, chaos_mul_q824: registered signed 32x32 multiply, 1-cycle latency, Q8.24 output slice.

Test Plan:
- Reset, then chaos_shift=32'h0010_0001 and one step edge -> done at cycle 5.
  - States: x=0x01010000, y=0x011A0000, z=0x00FE5800, w=0x00FF8000.
  - Outputs: chaos_x=0x01, chaos_y=0x1A, chaos_z=0xFE, chaos_w=0xFF.
- Same with OFS=24 (shift=32'h0018_0001) -> outputs x=0x01, y=0x01, z=0x00, w=0x00.
- OFS=31 -> clamped to 24; identical to the previous outputs.
- N=100: done at cycle 401. Comparing states against a bit-accurate reference model is the required response. Then N=0 behaves as N=1 (done at cycle 5).
- chaos_step held high 50 cycles -> exactly one run; a second edge during the run (step toggled) is ignored.
- chaos_reset asserted at cycle 3 of an N=10 run -> done stays 0, states = X0..W0.
  - The next step with N=1 reproduces the first scenario's values.
- Force x near 0x7F000000 with large dx -> result saturates to 0x7FFFFFFF, no sign flip.
- Async reset_n pulse mid-run -> all outputs 0 immediately, without a clock edge.
